// File: rtl/io_tile_pkg.sv
// Shared types and constants for the parametrised IO grid tile.
package io_tile_pkg;

    typedef enum logic [1:0] {
        UNCFG,
        SHIFT,
        PARTIAL,
        DONE
    } tile_state_e;

    localparam int unsigned CFG_DIR_BIT = 0;
    localparam int unsigned CFG_REG_BIT = 1;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/io_tile_channel.sv
// One IO channel: direction/data gating and optional output register.
module io_tile_channel
    import io_tile_pkg::*;
#(
    parameter int unsigned CFG_BITS = 2
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                active,
    input  logic [CFG_BITS-1:0] cfg,
    input  logic                io_outpad,
    input  logic                pad_IN,
    output logic                io_inpad,
    output logic                pad_OUT,
    output logic                pad_DIR
);

    logic dir;
    logic reg_mode;
    logic oreg;
    logic out_data;
    logic cfg_unused;

    assign dir        = cfg[CFG_DIR_BIT];
    assign reg_mode   = cfg[CFG_REG_BIT];
    // Reserved configuration bits are carried but have no effect.
    assign cfg_unused = ^cfg;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            oreg <= 1'b0;
        end else begin
            oreg <= io_outpad;
        end
    end

    assign out_data = reg_mode ? oreg : io_outpad;
    assign pad_DIR  = active & dir;
    assign pad_OUT  = active & dir & out_data;
    assign io_inpad = active & ~dir & pad_IN;

endmodule

// File: rtl/grid_io_tile_cfg_param.sv
// IO grid tile: configuration chain, shift counter, tracking FSM and channels.
module grid_io_tile_cfg_param
    import io_tile_pkg::*;
#(
    parameter int unsigned NUM_IO   = 8,
    parameter int unsigned CFG_BITS = 2
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              IO_ISOL_N,
    input  logic              ccff_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    output logic              cfg_done,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
    output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
    output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR
);

    localparam int unsigned L     = NUM_IO * CFG_BITS;
    localparam int unsigned CNT_W = clog2(L + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(L);

    logic [L-1:0]     chain;
    logic [CNT_W-1:0] cnt;
    tile_state_e      state;
    tile_state_e      state_nxt;
    logic             active;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            chain <= '0;
            cnt   <= '0;
            state <= UNCFG;
        end else begin
            if (ccff_en) begin
                chain <= {chain[L-2:0], ccff_head};
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNCFG:   if (ccff_en) state_nxt = SHIFT;
            SHIFT:   if (!ccff_en) state_nxt = (cnt == CNT_MAX) ? DONE : PARTIAL;
            PARTIAL: if (ccff_en) state_nxt = SHIFT;
            DONE:    if (ccff_en) state_nxt = SHIFT;
            default: state_nxt = UNCFG;
        endcase
    end

    assign ccff_tail = chain[L-1];
    assign cfg_done  = (state == DONE);
    assign active    = cfg_done & IO_ISOL_N;

    for (genvar k = 0; k < NUM_IO; k++) begin : g_ch
        io_tile_channel #(
            .CFG_BITS(CFG_BITS)
        ) u_ch (
            .prog_clk (prog_clk),
            .pReset   (pReset),
            .active   (active),
            .cfg      (chain[k*CFG_BITS +: CFG_BITS]),
            .io_outpad(io_outpad[k]),
            .pad_IN   (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k]),
            .io_inpad (io_inpad[k]),
            .pad_OUT  (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k]),
            .pad_DIR  (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k])
        );
    end

endmodule

// File: tb/tb_grid_io_tile_cfg_param.sv
// Directed and randomized checks of grid_io_tile_cfg_param against a shift-history model.
module tb_grid_io_tile_cfg_param;

    localparam int unsigned NUM_IO = 8;
    localparam int unsigned CB     = 2;
    localparam int unsigned L      = NUM_IO * CB;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              IO_ISOL_N;
    logic              ccff_en;
    logic              ccff_head;
    logic              ccff_tail;
    logic              cfg_done;
    logic [NUM_IO-1:0] io_outpad;
    logic [NUM_IO-1:0] io_inpad;
    logic [NUM_IO-1:0] pad_in;
    logic [NUM_IO-1:0] pad_out;
    logic [NUM_IO-1:0] pad_dir;

    grid_io_tile_cfg_param #(
        .NUM_IO  (NUM_IO),
        .CFG_BITS(CB)
    ) dut (
        .prog_clk                        (prog_clk),
        .pReset                          (pReset),
        .IO_ISOL_N                       (IO_ISOL_N),
        .ccff_en                         (ccff_en),
        .ccff_head                       (ccff_head),
        .ccff_tail                       (ccff_tail),
        .cfg_done                        (cfg_done),
        .io_outpad                       (io_outpad),
        .io_inpad                        (io_inpad),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_IN (pad_in),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT(pad_out),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR(pad_dir)
    );

    always #5 prog_clk = ~prog_clk;

    int compared   = 0;
    int mismatched = 0;

    // Model: hist[0] is the most recently shifted-in bit; the tile holds the last L bits.
    bit              hist[$];
    int unsigned     shifts;
    bit              done_m;
    logic [NUM_IO-1:0] oreg_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mbit(input int unsigned idx);
        return (idx < hist.size()) ? hist[idx] : 1'b0;
    endfunction

    task automatic check_all(input string tag);
        logic [NUM_IO-1:0] e_dir, e_out, e_in;
        bit act, d, r, e_tail;
        act = done_m & IO_ISOL_N;
        for (int unsigned k = 0; k < NUM_IO; k++) begin
            d = mbit(k*CB + 0);
            r = mbit(k*CB + 1);
            e_dir[k] = act & d;
            e_out[k] = act & d & (r ? oreg_m[k] : io_outpad[k]);
            e_in[k]  = act & ~d & pad_in[k];
        end
        e_tail = (hist.size() == L) ? hist[L-1] : 1'b0;
        chk({tag, "/tail"}, 64'(ccff_tail), 64'(e_tail));
        chk({tag, "/done"}, 64'(cfg_done), 64'(done_m));
        chk({tag, "/dir"},  64'(pad_dir), 64'(e_dir));
        chk({tag, "/out"},  64'(pad_out), 64'(e_out));
        chk({tag, "/inpad"}, 64'(io_inpad), 64'(e_in));
    endtask

    task automatic tick();
        @(posedge prog_clk);
        if (pReset) begin
            hist.delete();
            shifts = 0;
            done_m = 1'b0;
            oreg_m = '0;
        end else begin
            if (ccff_en) begin
                hist.push_front(ccff_head);
                if (hist.size() > L) void'(hist.pop_back());
                shifts++;
            end
            done_m = !ccff_en && (shifts >= L);
            oreg_m = io_outpad;
        end
        #1;
    endtask

    task automatic rand_data();
        io_outpad = NUM_IO'($urandom);
        pad_in    = NUM_IO'($urandom);
    endtask

    // Shifts w so that chain index i ends up holding w[i].
    task automatic shift_word(input logic [L-1:0] w, input string tag);
        for (int i = L - 1; i >= 0; i--) begin
            ccff_en   = 1'b1;
            ccff_head = w[i];
            rand_data();
            tick();
            check_all(tag);
        end
    endtask

    task automatic idle(input string tag);
        ccff_en = 1'b0;
        rand_data();
        tick();
        check_all(tag);
    endtask

    initial begin
        logic [L-1:0] w, w_prev;
        logic [3:0]   tog;
        logic [4:0]   lag;

        hist.delete();
        shifts = 0;
        done_m = 1'b0;
        oreg_m = '0;

        // Reset with shifting requested: reset wins.
        pReset = 1'b1; IO_ISOL_N = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1;
        rand_data();
        tick(); check_all("rst1");
        rand_data();
        tick(); check_all("rst2");
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_tail", 64'(ccff_tail), 64'd0);
        pReset = 1'b0;

        // Full configuration: ch0 DIR=1/REG=0, ch1 DIR=0, others random.
        w = L'($urandom);
        w[1:0] = 2'b01;
        w[2]   = 1'b0;
        shift_word(w, "full_shift");
        chk("full_not_done", 64'(cfg_done), 64'd0);
        idle("full_idle");
        chk("full_done", 64'(cfg_done), 64'd1);
        io_outpad[0] = 1'b1; #1;
        chk("full_out0", 64'(pad_out[0]), 64'd1);
        chk("full_dir0", 64'(pad_dir[0]), 64'd1);
        pad_in[1] = 1'b1; #1;
        chk("full_in1", 64'(io_inpad[1]), 64'd1);
        check_all("full_comb");

        // Isolation is combinational.
        IO_ISOL_N = 1'b0; #1;
        chk("iso_out", 64'(pad_out), 64'd0);
        chk("iso_dir", 64'(pad_dir), 64'd0);
        chk("iso_in", 64'(io_inpad), 64'd0);
        IO_ISOL_N = 1'b1; #1;
        chk("iso_back_out0", 64'(pad_out[0]), 64'd1);
        check_all("iso_back");

        // Partial: 10 bits, pause, then the last 6.
        pReset = 1'b1; tick(); pReset = 1'b0;
        check_all("part_rst");
        w = L'($urandom);
        w[1:0] = 2'b01;
        for (int i = L - 1; i >= 6; i--) begin
            ccff_en = 1'b1; ccff_head = w[i]; rand_data();
            tick(); check_all("part_a");
        end
        for (int i = 0; i < 5; i++) idle("part_wait");
        chk("part_done0", 64'(cfg_done), 64'd0);
        chk("part_dir0", 64'(pad_dir), 64'd0);
        for (int i = 5; i >= 0; i--) begin
            ccff_en = 1'b1; ccff_head = w[i]; rand_data();
            tick(); check_all("part_b");
        end
        idle("part_end");
        chk("part_done1", 64'(cfg_done), 64'd1);

        // Registered output on channel 3.
        w = L'($urandom);
        w[7:6] = 2'b11;
        shift_word(w, "reg_shift");
        ccff_en = 1'b0; rand_data(); io_outpad[3] = 1'b0;
        tick(); check_all("reg_pre");
        tog = 4'b0110;
        lag = 5'b01100;
        chk("reg_lag0", 64'(pad_out[3]), 64'(lag[0]));
        for (int i = 0; i < 4; i++) begin
            rand_data(); io_outpad[3] = tog[i];
            tick(); check_all("reg_step");
            chk("reg_lag", 64'(pad_out[3]), 64'(lag[i+1]));
        end
        w_prev = w;

        // Pass-through: the old bitstream leaves the tail, first-loaded bit first.
        w = L'($urandom);
        for (int i = 0; i < int'(L); i++) begin
            ccff_en = 1'b1; ccff_head = w[L-1-i]; rand_data(); #1;
            chk("pass_tail", 64'(ccff_tail), 64'(w_prev[L-1-i]));
            tick(); check_all("pass_shift");
            chk("pass_done0", 64'(cfg_done), 64'd0);
        end
        idle("pass_end");
        chk("pass_done1", 64'(cfg_done), 64'd1);

        // Reshift interrupted by reset at the seventh shift.
        w = L'($urandom);
        for (int i = 0; i < 6; i++) begin
            ccff_en = 1'b1; ccff_head = w[L-1-i]; rand_data();
            tick(); check_all("mid_shift");
        end
        pReset = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1; rand_data();
        tick(); check_all("mid_rst");
        chk("mid_rst_tail", 64'(ccff_tail), 64'd0);
        chk("mid_rst_out", 64'(pad_out | pad_dir | io_inpad), 64'd0);
        pReset = 1'b0;
        idle("mid_after");
        chk("mid_after_done", 64'(cfg_done), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            pReset    = ($urandom_range(0, 99) == 0);
            ccff_en   = ($urandom_range(0, 4) != 0);
            ccff_head = 1'($urandom);
            IO_ISOL_N = ($urandom_range(0, 7) != 0);
            rand_data();
            tick();
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
